// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-wide memory port between the
// instruction cache (refill reads) and the data cache (refills, block
// stores, and atomic evict-then-refill). All outputs are registered.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 256,
  parameter int OFF_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_ack,
  output logic [BLOCK_W-1:0] i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic               d_wb,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [ADDR_W-1:0]  d_wb_addr,
  input  logic [BLOCK_W-1:0] d_wdata,
  output logic               d_ack,
  output logic [BLOCK_W-1:0] d_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic               mem_ready,
  input  logic [BLOCK_W-1:0] mem_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  function automatic logic [ADDR_W-1:0] blk(input logic [ADDR_W-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  state_t             state_q, state_d;
  logic               last_d_q, last_d_d;   // last_grant: 1 = dcache, 0 = icache
  logic               win_d_q, win_d_d;     // current grant belongs to dcache
  logic               evict_q, evict_d;     // write phase is followed by a refill read
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d; // refill address held across the write phase
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0] mem_wdata_q, mem_wdata_d;
  logic               i_ack_q, i_ack_d;
  logic               d_ack_q, d_ack_d;
  logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;
  logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;
  logic               busy_q, busy_d;
  logic               grant_dc;

  // Next-state and registered-output computation for the arbiter FSM
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    win_d_d     = win_d_q;
    evict_d     = evict_q;
    rd_addr_d   = rd_addr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_dc    = d_req && (!i_req || !last_d_q);

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (i_req && d_req) last_d_d = grant_dc;
          win_d_d   = grant_dc;
          mem_req_d = 1'b1;
          evict_d   = 1'b0;
          if (grant_dc) begin
            mem_wdata_d = d_wdata;
            rd_addr_d   = blk(d_addr);
            if (d_we) begin
              state_d    = WRITE;
              mem_we_d   = 1'b1;
              mem_addr_d = blk(d_addr);
            end else if (d_wb) begin
              state_d    = WRITE;
              evict_d    = 1'b1;
              mem_we_d   = 1'b1;
              mem_addr_d = blk(d_wb_addr);
            end else begin
              state_d    = READ;
              mem_we_d   = 1'b0;
              mem_addr_d = blk(d_addr);
            end
          end else begin
            state_d    = READ;
            mem_we_d   = 1'b0;
            mem_addr_d = blk(i_addr);
          end
        end
      end
      WRITE: begin
        if (mem_ready) begin
          mem_we_d = 1'b0;
          if (evict_q) begin
            // refill follows the eviction on the same edge, keeping mem_req high
            state_d    = READ;
            mem_addr_d = rd_addr_q;
          end else begin
            state_d   = DONE;
            mem_req_d = 1'b0;
            d_ack_d   = 1'b1;
          end
        end
      end
      READ: begin
        if (mem_ready) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (win_d_q) begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_ack_d   = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      win_d_q     <= 1'b0;
      evict_q     <= 1'b0;
      rd_addr_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      win_d_q     <= win_d_d;
      evict_q     <= evict_d;
      rd_addr_q   <= rd_addr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: acts as both caches and the block memory, with a
// transaction-level model of arbitration, phase sequencing and memory contents.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_req, d_req, d_we, d_wb, mem_ready;
  logic [31:0]  i_addr, d_addr, d_wb_addr;
  logic [255:0] d_wdata, mem_rdata;
  logic         i_ack, d_ack, mem_req, mem_we, busy;
  logic [255:0] i_rdata, d_rdata, mem_wdata;
  logic [31:0]  mem_addr;

  mem_arbiter #(.ADDR_W(32), .BLOCK_W(256), .OFF_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wb(d_wb), .d_addr(d_addr),
    .d_wb_addr(d_wb_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // model state
  logic         last_d;          // 1 = dcache won the last collision
  logic [255:0] exp_i_rdata, exp_d_rdata;
  logic [255:0] mem_m [logic [31:0]];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_mreq"}, mem_req, 1'b0);
    check_eq({tag, "_iack"}, i_ack, 1'b0);
    check_eq({tag, "_dack"}, d_ack, 1'b0);
  endtask

  // One arbitration round: present requests, then act as memory for the winner.
  task automatic txn(input logic ir, input logic dr, input logic [31:0] ia,
                     input logic we, input logic wb, input logic [31:0] da,
                     input logic [31:0] wba, input logic [255:0] wd,
                     input int unsigned dly);
    logic        wind;
    int unsigned nph;
    logic        ph_we [2];
    logic [31:0] ph_addr [2];
    i_req = ir; d_req = dr; i_addr = ia; d_we = we; d_wb = wb;
    d_addr = da; d_wb_addr = wba; d_wdata = wd;
    mem_ready = 1'($urandom_range(0, 1));   // ignored while no mem_req
    if (!ir && !dr) begin
      @(posedge clk); #1;
      check_idle("noreq");
      mem_ready = 1'b0;
      return;
    end
    wind = dr && (!ir || !last_d);
    if (ir && dr) last_d = wind;
    if (wind && we) begin
      nph = 1; ph_we[0] = 1'b1; ph_addr[0] = align(da);
    end else if (wind && wb) begin
      nph = 2; ph_we[0] = 1'b1; ph_addr[0] = align(wba);
      ph_we[1] = 1'b0; ph_addr[1] = align(da);
    end else begin
      nph = 1; ph_we[0] = 1'b0; ph_addr[0] = align(wind ? da : ia);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    // inputs other than the request levels may now change freely
    i_addr = $urandom; d_addr = $urandom; d_wb_addr = $urandom;
    d_wdata = rand256(); d_we = 1'($urandom); d_wb = 1'($urandom);
    for (int unsigned p = 0; p < nph; p++) begin
      for (int unsigned c = 0; c <= dly; c++) begin
        check_eq("mem_req", mem_req, 1'b1);
        check_eq("mem_we", mem_we, ph_we[p]);
        check_eq("mem_addr", mem_addr, ph_addr[p]);
        if (ph_we[p]) check_eq("mem_wdata", mem_wdata, wd);
        check_eq("busy", busy, 1'b1);
        check_eq("i_ack_early", i_ack, 1'b0);
        check_eq("d_ack_early", d_ack, 1'b0);
        if (c == dly) begin
          mem_ready = 1'b1;
          if (!ph_we[p]) mem_rdata = mem_rd(ph_addr[p]);
        end
        @(posedge clk); #1;
        if (c == dly && ph_we[p]) mem_m[ph_addr[p]] = wd;
        mem_ready = 1'b0;
        mem_rdata = rand256();
      end
    end
    if (!ph_we[nph-1]) begin
      if (wind) exp_d_rdata = mem_rd(ph_addr[nph-1]);
      else      exp_i_rdata = mem_rd(ph_addr[nph-1]);
    end
    check_eq("i_ack", i_ack, !wind);
    check_eq("d_ack", d_ack, wind);
    check_eq("done_mreq", mem_req, 1'b0);
    check_eq("done_busy", busy, 1'b1);
    check_eq("i_rdata", i_rdata, exp_i_rdata);
    check_eq("d_rdata", d_rdata, exp_d_rdata);
    if (wind) d_req = 1'b0; else i_req = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    check_idle("after");
    mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] pat_a;
    logic [1:0]   r;
    rst_n = 1'b0; i_req = 0; d_req = 0; d_we = 0; d_wb = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_wb_addr = '0; d_wdata = '0; mem_rdata = '0;
    last_d = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check_eq("reset_we", mem_we, 1'b0);
    check_eq("reset_addr", mem_addr, 32'h0);
    check_eq("reset_wdata", mem_wdata, 256'h0);
    check_eq("reset_irdata", i_rdata, 256'h0);
    check_eq("reset_drdata", d_rdata, 256'h0);
    #2 rst_n = 1'b1;

    // single icache refill
    pat_a = {8{32'hA5A5_1234}};
    mem_m[32'h0000_1220] = pat_a;
    txn(1, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 0);
    check_eq("pattern_a", i_rdata, pat_a);

    // collisions: dcache first after reset, then icache, then alternate
    txn(1, 1, 32'h0000_0300, 0, 0, 32'h0000_0040, 0, 0, 0);
    txn(1, 0, 32'h0000_0300, 0, 0, 0, 0, 0, 0);
    txn(1, 1, 32'h0000_0500, 0, 0, 32'h0000_0060, 0, 0, 1);
    txn(0, 1, 0, 0, 0, 32'h0000_0060, 0, 0, 0);

    // evict-then-refill with icache pending, two wait cycles per phase
    txn(1, 1, 32'h0000_0700, 0, 1, 32'h0000_01C0, 32'h0000_0080, rand256(), 2);
    txn(1, 0, 32'h0000_0700, 0, 0, 0, 0, 0, 0);

    // store with d_wb also high: one write, d_rdata untouched
    txn(0, 1, 0, 1, 1, 32'h0000_003F, 32'h0000_0100, rand256(), 0);
    txn(0, 1, 0, 0, 0, 32'h0000_0020, 0, 0, 0);

    // long wait states
    txn(1, 0, 32'h0000_0080, 0, 0, 0, 0, 0, 10);

    // reset mid-read
    i_req = 1'b1; i_addr = 32'h0000_0500; mem_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_pre_mreq", mem_req, 1'b1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    check_eq("rst_mid_irdata", i_rdata, 256'h0);
    i_req = 1'b0; last_d = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check_idle("rst_after");
    end
    mem_ready = 1'b0;
    txn(1, 0, 32'h0000_0520, 0, 0, 0, 0, 0, 1);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      r = 2'($urandom_range(0, 3));
      txn(r[0], r[1],
          ($urandom_range(0, 15) << 5) | $urandom_range(0, 31),
          1'($urandom_range(0, 3) == 0), 1'($urandom),
          ($urandom_range(0, 15) << 5) | $urandom_range(0, 31),
          ($urandom_range(0, 15) << 5) | $urandom_range(0, 31),
          rand256(), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
